// File: rtl/ipg_wreq_engine.sv
// IPG write-request receiver: parses FIRST / address / data / LAST blocks into a
// header bundle and RAM write port, with length checking, idle timeout and abort codes.
module ipg_wreq_engine #(
    parameter int         DATA_WIDTH    = 64,
    parameter int         PL_WIDTH      = DATA_WIDTH - 8,
    parameter int         NUM_ADDR_BLKS = 2,
    parameter int         ADR_WIDTH     = 12,
    parameter int         LEN_WIDTH     = 16,
    parameter int         MAX_IDLE      = 4,
    parameter logic [7:0] BT_FIRST      = 8'h2c,
    parameter logic [7:0] BT_WRITE      = 8'h1c,
    parameter logic [7:0] BT_LAST       = 8'h0c
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             rx_ipg_data,
    input  logic                              wreq_valid,
    output logic [PL_WIDTH-1:0]               hdr_out,
    output logic [NUM_ADDR_BLKS*PL_WIDTH-1:0] addr_out,
    output logic                              hdr_valid,
    output logic                              wr_en,
    output logic [ADR_WIDTH-1:0]              wr_addr,
    output logic [PL_WIDTH-1:0]               wr_data,
    output logic [PL_WIDTH/8-1:0]             wr_strb,
    output logic                              msg_done,
    output logic                              msg_err,
    output logic [2:0]                        err_code,
    output logic                              busy
);

    localparam int PB  = PL_WIDTH / 8;
    localparam int CW  = LEN_WIDTH + 1;
    localparam int AIW = (NUM_ADDR_BLKS > 1) ? $clog2(NUM_ADDR_BLKS) : 1;
    localparam int IW  = $clog2(MAX_IDLE + 1);

    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_BADTYPE = 3'd2;
    localparam logic [2:0] ERR_SHORT   = 3'd3;
    localparam logic [2:0] ERR_LEN     = 3'd4;
    localparam logic [2:0] ERR_RESTART = 3'd5;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                          state_q, state_d;
    logic [LEN_WIDTH-1:0]            len_q, len_d;
    logic [CW-1:0]                   byte_cnt_q, byte_cnt_d;
    logic [AIW-1:0]                  addr_idx_q, addr_idx_d;
    logic [IW-1:0]                   idle_q, idle_d;
    logic [ADR_WIDTH-1:0]            wr_ptr_q, wr_ptr_d;

    logic [PL_WIDTH-1:0]             hdr_d;
    logic [NUM_ADDR_BLKS*PL_WIDTH-1:0] addr_d;
    logic                            hdr_valid_d, wr_en_d, msg_done_d, msg_err_d;
    logic [ADR_WIDTH-1:0]            wr_addr_d;
    logic [PL_WIDTH-1:0]             wr_data_d;
    logic [PB-1:0]                   wr_strb_d;
    logic [2:0]                      err_code_d;

    logic [7:0]                      blk_type;
    logic [PL_WIDTH-1:0]             payload;
    logic [CW-1:0]                   rem;
    logic                            start, abort;
    logic [2:0]                      abort_code;

    assign blk_type = rx_ipg_data[7:0];
    assign payload  = rx_ipg_data[8 +: PL_WIDTH];
    assign busy     = (state_q != IDLE);

    // Low n byte lanes enabled; n is at most PB when used.
    function automatic logic [PB-1:0] strb_mask(input logic [CW-1:0] n);
        logic [PB-1:0] m;
        for (int i = 0; i < PB; i++) m[i] = (CW'(i) < n);
        return m;
    endfunction

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        addr_idx_d  = addr_idx_q;
        idle_d      = idle_q;
        wr_ptr_d    = wr_ptr_q;
        hdr_d       = hdr_out;
        addr_d      = addr_out;
        hdr_valid_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        wr_strb_d   = wr_strb;
        msg_done_d  = 1'b0;
        msg_err_d   = 1'b0;
        err_code_d  = err_code;
        rem         = CW'(len_q) - byte_cnt_q;
        start       = 1'b0;
        abort       = 1'b0;
        abort_code  = 3'd0;

        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (wreq_valid && blk_type == BT_FIRST) start = 1'b1;
            end
            ADDR, DATA: begin
                if (!wreq_valid) begin
                    if (idle_q == IW'(MAX_IDLE - 1)) begin
                        abort      = 1'b1;
                        abort_code = ERR_TIMEOUT;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end else begin
                    idle_d = '0;
                    if (blk_type == BT_FIRST) begin
                        // Report the abandoned message, then restart on this header.
                        abort      = 1'b1;
                        abort_code = ERR_RESTART;
                        start      = 1'b1;
                    end else if (state_q == ADDR) begin
                        if (blk_type == BT_WRITE) begin
                            for (int i = 0; i < NUM_ADDR_BLKS; i++)
                                if (addr_idx_q == AIW'(i))
                                    addr_d[(NUM_ADDR_BLKS-1-i)*PL_WIDTH +: PL_WIDTH] = payload;
                            if (addr_idx_q == AIW'(NUM_ADDR_BLKS - 1)) begin
                                hdr_valid_d = 1'b1;
                                wr_ptr_d    = payload[ADR_WIDTH-1:0];
                                state_d     = DATA;
                            end else begin
                                addr_idx_d = addr_idx_q + 1'b1;
                            end
                        end else if (blk_type == BT_LAST) begin
                            abort      = 1'b1;
                            abort_code = ERR_SHORT;
                        end else begin
                            abort      = 1'b1;
                            abort_code = ERR_BADTYPE;
                        end
                    end else begin
                        if (blk_type == BT_WRITE) begin
                            // A full block must leave at least one byte for LAST.
                            if (byte_cnt_q + CW'(PB) >= CW'(len_q)) begin
                                abort      = 1'b1;
                                abort_code = ERR_LEN;
                            end else begin
                                wr_en_d    = 1'b1;
                                wr_addr_d  = wr_ptr_q;
                                wr_data_d  = payload;
                                wr_strb_d  = '1;
                                wr_ptr_d   = wr_ptr_q + 1'b1;
                                byte_cnt_d = byte_cnt_q + CW'(PB);
                            end
                        end else if (blk_type == BT_LAST) begin
                            if (rem != '0 && rem <= CW'(PB)) begin
                                wr_en_d    = 1'b1;
                                wr_addr_d  = wr_ptr_q;
                                wr_data_d  = payload;
                                wr_strb_d  = strb_mask(rem);
                                msg_done_d = 1'b1;
                                state_d    = IDLE;
                            end else begin
                                abort      = 1'b1;
                                abort_code = ERR_LEN;
                            end
                        end else begin
                            abort      = 1'b1;
                            abort_code = ERR_BADTYPE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            msg_err_d  = 1'b1;
            err_code_d = abort_code;
            state_d    = IDLE;
        end
        if (start) begin
            hdr_d      = payload;
            len_d      = payload[LEN_WIDTH-1:0];
            byte_cnt_d = '0;
            addr_idx_d = '0;
            idle_d     = '0;
            state_d    = ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            addr_idx_q <= '0;
            idle_q     <= '0;
            wr_ptr_q   <= '0;
            hdr_out    <= '0;
            addr_out   <= '0;
            hdr_valid  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_strb    <= '0;
            msg_done   <= 1'b0;
            msg_err    <= 1'b0;
            err_code   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            addr_idx_q <= addr_idx_d;
            idle_q     <= idle_d;
            wr_ptr_q   <= wr_ptr_d;
            hdr_out    <= hdr_d;
            addr_out   <= addr_d;
            hdr_valid  <= hdr_valid_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            wr_strb    <= wr_strb_d;
            msg_done   <= msg_done_d;
            msg_err    <= msg_err_d;
            err_code   <= err_code_d;
        end
    end

endmodule

// File: tb/tb_ipg_wreq_engine.sv
// Scoreboard bench for ipg_wreq_engine: message-level reference model pushes expected
// output events; a negedge monitor pops and compares whatever the DUT presents.
module tb_ipg_wreq_engine;
    localparam int DW = 64, PL = 56, NA = 2, AW = 12, LW = 16, MI = 4, PB = PL / 8;
    localparam logic [7:0] T_FIRST = 8'h2c, T_WRITE = 8'h1c, T_LAST = 8'h0c;

    logic              clk, reset, wreq_valid;
    logic [DW-1:0]     rx_ipg_data;
    logic [PL-1:0]     hdr_out, wr_data;
    logic [NA*PL-1:0]  addr_out;
    logic              hdr_valid, wr_en, msg_done, msg_err, busy;
    logic [AW-1:0]     wr_addr;
    logic [PB-1:0]     wr_strb;
    logic [2:0]        err_code;

    ipg_wreq_engine #(
        .DATA_WIDTH(DW), .PL_WIDTH(PL), .NUM_ADDR_BLKS(NA), .ADR_WIDTH(AW),
        .LEN_WIDTH(LW), .MAX_IDLE(MI),
        .BT_FIRST(T_FIRST), .BT_WRITE(T_WRITE), .BT_LAST(T_LAST)
    ) dut (
        .clk(clk), .reset(reset), .rx_ipg_data(rx_ipg_data), .wreq_valid(wreq_valid),
        .hdr_out(hdr_out), .addr_out(addr_out), .hdr_valid(hdr_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .msg_done(msg_done), .msg_err(msg_err), .err_code(err_code), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit             hv, we, dn, er, bz;
        logic [PL-1:0]  hdr;
        logic [NA*PL-1:0] adr;
        logic [AW-1:0]  wa;
        logic [PL-1:0]  wd;
        logic [PB-1:0]  ws;
        logic [2:0]     ec;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;

    function automatic ev_t blank();
        ev_t e;
        e.hv = 0; e.we = 0; e.dn = 0; e.er = 0; e.bz = 0;
        e.hdr = '0; e.adr = '0; e.wa = '0; e.wd = '0; e.ws = '0; e.ec = '0;
        return e;
    endfunction

    function automatic void push_err(input logic [2:0] c, input bit bz);
        ev_t e = blank();
        e.er = 1; e.ec = c; e.bz = bz;
        q.push_back(e);
    endfunction

    function automatic void push_wr(input logic [AW-1:0] wa, input logic [PL-1:0] wd,
                                    input logic [PB-1:0] ws, input bit dn);
        ev_t e = blank();
        e.we = 1; e.wa = wa; e.wd = wd; e.ws = ws; e.dn = dn; e.bz = !dn;
        q.push_back(e);
    endfunction

    function automatic void push_hdr(input logic [PL-1:0] h, input logic [NA*PL-1:0] a);
        ev_t e = blank();
        e.hv = 1; e.hdr = h; e.adr = a; e.bz = 1;
        q.push_back(e);
    endfunction

    // Monitor: one comparison per cycle in which the DUT presents any output pulse.
    ev_t m_e;
    bit  m_bad;
    always @(negedge clk) begin
        if (hdr_valid || wr_en || msg_done || msg_err) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got hv=%0b we=%0b dn=%0b er=%0b wa=%h ec=%0d, required no output",
                         hdr_valid, wr_en, msg_done, msg_err, wr_addr, err_code);
            end else begin
                m_e = q.pop_front();
                m_bad = (hdr_valid != m_e.hv) || (wr_en != m_e.we) || (msg_done != m_e.dn) ||
                        (msg_err != m_e.er) || (busy != m_e.bz) ||
                        (m_e.hv && (hdr_out != m_e.hdr || addr_out != m_e.adr)) ||
                        (m_e.we && (wr_addr != m_e.wa || wr_data != m_e.wd || wr_strb != m_e.ws)) ||
                        (m_e.er && err_code != m_e.ec);
                if (m_bad) begin
                    failures++;
                    $display("FAIL event: got hv=%0b we=%0b dn=%0b er=%0b bz=%0b hdr=%h adr=%h wa=%h wd=%h ws=%h ec=%0d; required hv=%0b we=%0b dn=%0b er=%0b bz=%0b hdr=%h adr=%h wa=%h wd=%h ws=%h ec=%0d",
                             hdr_valid, wr_en, msg_done, msg_err, busy, hdr_out, addr_out, wr_addr, wr_data, wr_strb, err_code,
                             m_e.hv, m_e.we, m_e.dn, m_e.er, m_e.bz, m_e.hdr, m_e.adr, m_e.wa, m_e.wd, m_e.ws, m_e.ec);
                end
            end
        end
    end

    function automatic logic [PL-1:0] rnd_pl();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PL-1:0];
    endfunction

    task automatic drive(input bit v, input logic [7:0] t, input logic [PL-1:0] p);
        wreq_valid  = v;
        rx_ipg_data = {p, t};
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        drive(1'b0, 8'($urandom()), rnd_pl());
    endtask

    task automatic gap(input int lo, input int hi);
        repeat ($urandom_range(hi, lo)) idle1();
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (hdr_valid || wr_en || msg_done || msg_err || busy || hdr_out != '0 || addr_out != '0 ||
            wr_addr != '0 || wr_data != '0 || wr_strb != '0 || err_code != '0) begin
            failures++;
            $display("FAIL %s: got hv=%0b we=%0b dn=%0b er=%0b busy=%0b hdr=%h adr=%h wa=%h wd=%h ws=%h ec=%0d, required all zero",
                     nm, hdr_valid, wr_en, msg_done, msg_err, busy, hdr_out, addr_out, wr_addr, wr_data, wr_strb, err_code);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'($urandom()), T_FIRST, rnd_pl());
        check_zero("reset_mid_msg");
        reset = 1'b0;
    endtask

    // Faults: 1 SHORT, 2 bad type, 4 timeout, 6 restart (address phase);
    //         3 bad type, 5 timeout, 7 restart, 8 abandon (data phase).
    task automatic fault_act(input int fault, input logic [7:0] badt, output bit open);
        open = 1'b0;
        case (fault)
            1: begin push_err(3'd3, 1'b0); drive(1'b1, T_LAST, rnd_pl()); end
            2, 3: begin push_err(3'd2, 1'b0); drive(1'b1, badt, rnd_pl()); end
            4, 5: begin
                repeat (MI - 1) idle1();
                push_err(3'd1, 1'b0);
                idle1();
            end
            default: open = 1'b1;
        endcase
    endtask

    task automatic send_msg(input int len, input int dst, input int nwr, input int fault,
                            input int fpos, input logic [7:0] badt, input int glo, input int ghi,
                            input bit restart, output bit open);
        logic [PL-1:0]    hdr, a, d;
        logic [NA*PL-1:0] adr;
        int               rem;
        bit               afault, dfault;
        afault = (fault == 1 || fault == 2 || fault == 4 || fault == 6);
        dfault = (fault == 3 || fault == 5 || fault == 7 || fault == 8);
        open = 1'b0;
        adr = '0;
        hdr = rnd_pl();
        hdr[LW-1:0] = LW'(len);
        gap(glo, ghi);
        if (restart) push_err(3'd5, 1'b1);
        drive(1'b1, T_FIRST, hdr);
        for (int i = 0; i < NA; i++) begin
            if (afault && fpos == i) begin fault_act(fault, badt, open); return; end
            gap(glo, ghi);
            a = rnd_pl();
            if (i == NA - 1) a[AW-1:0] = AW'(dst);
            adr[(NA-1-i)*PL +: PL] = a;
            if (i == NA - 1) push_hdr(hdr, adr);
            drive(1'b1, T_WRITE, a);
        end
        for (int i = 0; i < nwr; i++) begin
            if (dfault && fpos == i) begin fault_act(fault, badt, open); return; end
            gap(glo, ghi);
            d = rnd_pl();
            if (PB * (i + 1) >= len) begin
                push_err(3'd4, 1'b0);
                drive(1'b1, T_WRITE, d);
                return;
            end
            push_wr(AW'(dst + i), d, '1, 1'b0);
            drive(1'b1, T_WRITE, d);
        end
        if (dfault && fpos == nwr) begin fault_act(fault, badt, open); return; end
        gap(glo, ghi);
        d = rnd_pl();
        rem = len - PB * nwr;
        if (rem >= 1 && rem <= PB) push_wr(AW'(dst + nwr), d, PB'((1 << rem) - 1), 1'b1);
        else push_err(3'd4, 1'b0);
        drive(1'b1, T_LAST, d);
    endtask

    function automatic logic [7:0] rnd_badt();
        logic [7:0] t;
        do t = 8'($urandom_range(0, 255));
        while (t == T_FIRST || t == T_WRITE || t == T_LAST);
        return t;
    endfunction

    initial begin
        bit          op;
        int          f, fault, len, nwr, fpos;
        logic [7:0]  jt;
        reset = 1'b1;
        wreq_valid = 1'b0;
        rx_ipg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;

        // Directed scenarios
        send_msg(10, 'h100, 1, 0, 0, 8'h55, 0, 0, 1'b0, op);
        send_msg(14, 'hFFF, 1, 0, 0, 8'h55, 0, 0, 1'b0, op);
        send_msg(20, 'h010, 2, 0, 0, 8'h55, 3, 3, 1'b0, op);
        send_msg(30, 'h020, 2, 5, 1, 8'h55, 0, 0, 1'b0, op);
        send_msg(5,  'h030, 1, 0, 0, 8'h55, 0, 0, 1'b0, op);
        send_msg(20, 'h040, 1, 0, 0, 8'h55, 0, 0, 1'b0, op);
        send_msg(30, 'h050, 1, 1, 1, 8'h55, 0, 0, 1'b0, op);
        send_msg(30, 'h060, 2, 3, 0, 8'h55, 0, 0, 1'b0, op);
        send_msg(30, 'h070, 2, 7, 1, 8'h55, 0, 0, 1'b0, op);
        send_msg(12, 'h200, 1, 0, 0, 8'h55, 0, 0, op, op);
        send_msg(0,  'h210, 0, 0, 0, 8'h55, 0, 0, 1'b0, op);
        send_msg(40, 'h300, 3, 8, 1, 8'h55, 0, 1, 1'b0, op);
        do_reset();
        send_msg(10, 'h100, 1, 0, 0, 8'h55, 0, 0, 1'b0, op);

        // Randomized messages
        op = 1'b0;
        for (int n = 0; n < 300; n++) begin
            f = $urandom_range(0, 15);
            fault = (f < 8) ? 0 : f - 7;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 50);
            if ($urandom_range(0, 1) == 1 && len > 0) nwr = (len - 1) / PB;
            else nwr = $urandom_range(0, 8);
            if (nwr > 8) nwr = $urandom_range(0, 8);
            if (fault == 1 || fault == 2 || fault == 4 || fault == 6) fpos = $urandom_range(0, NA - 1);
            else fpos = $urandom_range(0, nwr);
            send_msg(len, $urandom_range(0, 4095), nwr, fault, fpos, rnd_badt(),
                     0, $urandom_range(0, 3), op, op);
            if (fault == 8) begin
                do_reset();
                op = 1'b0;
            end
            if (!op && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: jt = T_WRITE;
                    1: jt = T_LAST;
                    default: jt = rnd_badt();
                endcase
                drive(1'b1, jt, rnd_pl());
            end
        end
        if (op) send_msg(10, 'h123, 1, 0, 0, 8'h55, 0, 0, 1'b1, op);
        repeat (3) idle1();

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected events, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
